// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter (SLL / SRL / SRA / ROL).
// Stage i shifts by 2^i when bit i of the effective shift amount is set.
// Shift amount, mode and sign travel with the data. A single global stall
// (out_valid & ~out_ready) freezes every stage, and bubbles are kept.
// Optional feature: define BARREL_SHIFTER_CARRY_EN to add the carry_out port,
// which returns the last bit shifted out of the word.
module barrel_shifter_pipe #(
    parameter int WIDTH  = 16,
    parameter int SHW    = $clog2(WIDTH),
    parameter int STAGES = SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q
`ifdef BARREL_SHIFTER_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic stall;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       m,
                                                  input logic             sg,
                                                  input int               amt);
        logic [WIDTH-1:0] fill;
        fill = sg ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (m)
            MODE_SLL: shift_by = d << amt;
            MODE_SRL: shift_by = d >> amt;
            MODE_SRA: shift_by = (d >> amt) | fill;
            default:  shift_by = (d << amt) | (d >> (WIDTH - amt));
        endcase
    endfunction

`ifdef BARREL_SHIFTER_CARRY_EN
    // The last bit leaving the word in this stage; later stages overwrite it,
    // so the final value is the last bit shifted out overall.
    function automatic logic carry_by(input logic [WIDTH-1:0] d,
                                      input logic [1:0]       m,
                                      input int               amt);
        logic [WIDTH-1:0] t;
        if (m == MODE_SLL || m == MODE_ROL) t = d >> (WIDTH - amt);
        else                                t = d >> (amt - 1);
        carry_by = t[0];
    endfunction
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             in_vld;
        logic [WIDTH-1:0] in_d;
        logic [1:0]       in_m;
        logic [SHW-1:i]   in_sh;
        logic             in_sg;
        logic [WIDTH-1:0] nxt_d;
        logic             vld;
        logic [WIDTH-1:0] d;

        if (i == 0) begin : g_src
            assign in_vld = in_valid & in_ready;
            assign in_d   = data;
            assign in_m   = mode;
            assign in_sh  = en ? shamt : '0;
            assign in_sg  = data[WIDTH-1];
        end else begin : g_src
            assign in_vld = g_stage[i-1].vld;
            assign in_d   = g_stage[i-1].d;
            assign in_m   = g_stage[i-1].g_fwd.m;
            assign in_sh  = g_stage[i-1].g_fwd.sh;
            assign in_sg  = g_stage[i-1].g_fwd.sg;
        end

        // Shift by 2^i when this stage's shift-amount bit is set.
        always_comb begin
            nxt_d = in_d;
            if (in_sh[i]) nxt_d = shift_by(in_d, in_m, in_sg, 1 << i);
        end

        // Stage valid and data advance together unless the pipe is stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= 1'b0;
                d   <= '0;
            end else if (!stall) begin
                vld <= in_vld;
                d   <= nxt_d;
            end
        end

        if (i < STAGES - 1) begin : g_fwd
            logic [1:0]       m;
            logic [SHW-1:i+1] sh;
            logic             sg;

            // Side-band fields needed by later stages only.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m  <= '0;
                    sh <= '0;
                    sg <= 1'b0;
                end else if (!stall) begin
                    m  <= in_m;
                    sh <= in_sh[SHW-1:i+1];
                    sg <= in_sg;
                end
            end
        end

`ifdef BARREL_SHIFTER_CARRY_EN
        logic in_cy;
        logic nxt_cy;
        logic cy;

        if (i == 0) begin : g_cy_src
            assign in_cy = 1'b0;
        end else begin : g_cy_src
            assign in_cy = g_stage[i-1].cy;
        end

        // Carry tracks the most recent bit shifted out of the word.
        always_comb begin
            nxt_cy = in_cy;
            if (in_sh[i]) nxt_cy = carry_by(in_d, in_m, 1 << i);
        end

        // Carry register moves in lock-step with the data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         cy <= 1'b0;
            else if (!stall) cy <= nxt_cy;
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].vld;
    assign q         = g_stage[STAGES-1].d;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~rst;
`ifdef BARREL_SHIFTER_CARRY_EN
    assign carry_out = g_stage[STAGES-1].cy;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe (WIDTH=16, latency 4). Directed vectors,
// back-pressure, mid-stream reset and randomized traffic against a scoreboard.
// Define BARREL_SHIFTER_CARRY_EN to also exercise carry_out.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;
    localparam int W   = 16;
    localparam int LAT = 4;
    localparam logic [1:0] SLL = 2'd0, SRL = 2'd1, SRA = 2'd2, ROL = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data = '0;
    logic [3:0]   shamt = '0;
    logic [1:0]   mode = '0;
    logic         en = 1'b1;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] q;
`ifdef BARREL_SHIFTER_CARRY_EN
    logic         carry_out;
`endif

    barrel_shifter_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .shamt     (shamt),
        .mode      (mode),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
`ifdef BARREL_SHIFTER_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the effective shift amount.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] d, input int k, input logic [1:0] m);
        case (m)
            SLL:     return d << k;
            SRL:     return d >> k;
            SRA:     return W'($signed(d) >>> k);
            default: return (d << k) | (d >> (W - k));
        endcase
    endfunction

    function automatic logic ref_c(input logic [W-1:0] d, input int k, input logic [1:0] m);
        if (k == 0) return 1'b0;
        if (m == SLL || m == ROL) return d[W-k];
        return d[k-1];
    endfunction

    typedef struct {
        logic [W-1:0] q;
        logic         c;
        int           cyc;
        int           stl;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] out_log[$];
    int           cyc = 0;
    int           stall_cnt = 0;

    // Monitor: mid-cycle sampling of both handshakes.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_q;
        prev_stall = 1'b0;
        prev_q     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold_q", q, prev_q);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("out_with_empty_sb", 32'(out_valid), 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("model_q", q, e.q);
                        chk("latency", cyc - e.cyc, LAT + stall_cnt - e.stl);
`ifdef BARREL_SHIFTER_CARRY_EN
                        chk("model_carry", carry_out, e.c);
`endif
                        out_log.push_back(q);
                    end
                end
                if (out_valid && !out_ready) stall_cnt++;
                if (in_valid && in_ready) begin
                    exp_t n;
                    int   k;
                    k     = en ? int'(shamt) : 0;
                    n.q   = ref_q(data, k, mode);
                    n.c   = ref_c(data, k, mode);
                    n.cyc = cyc;
                    n.stl = stall_cnt;
                    sb.push_back(n);
                end
                prev_stall = out_valid && !out_ready;
                prev_q     = q;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [3:0] sh, input logic [1:0] m, input logic e);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        data     = d;
        shamt    = sh;
        mode     = m;
        en       = e;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
    endtask

    // Word accepted at the last edge must show up exactly LAT edges later.
    task automatic expect_out(input string name, input logic [W-1:0] eq, input logic ec);
        repeat (LAT - 2) @(posedge clk);
        #1;
        chk({name, "_early"}, 32'(out_valid), 0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(out_valid), 1);
        chk({name, "_q"}, q, eq);
`ifdef BARREL_SHIFTER_CARRY_EN
        chk({name, "_carry"}, carry_out, ec);
`else
        if (ec === 1'bx) $display("unexpected x carry in %s", name);
`endif
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [3:0]   sh;
        logic [1:0]   m;
        logic         e;
        logic [W-1:0] eq;
        logic         ec;
    } vec_t;

    bit rnd_done = 1'b0;

    initial begin
        vec_t vt[12];
        vt[0]  = '{16'hAAAA, 4'd8,  SLL, 1'b1, 16'hAA00, 1'b0};
        vt[1]  = '{16'h8000, 4'd3,  SRA, 1'b1, 16'hF000, 1'b0};
        vt[2]  = '{16'h8000, 4'd3,  SRL, 1'b1, 16'h1000, 1'b0};
        vt[3]  = '{16'h1234, 4'd4,  ROL, 1'b1, 16'h2341, 1'b1};
        vt[4]  = '{16'hCCCC, 4'd5,  SLL, 1'b0, 16'hCCCC, 1'b0};
        vt[5]  = '{16'hF0F0, 4'd0,  SLL, 1'b1, 16'hF0F0, 1'b0};
        vt[6]  = '{16'h8001, 4'd1,  SLL, 1'b1, 16'h0002, 1'b1};
        vt[7]  = '{16'h0001, 4'd1,  SRL, 1'b1, 16'h0000, 1'b1};
        vt[8]  = '{16'h8421, 4'd15, ROL, 1'b1, 16'hC210, 1'b0};
        vt[9]  = '{16'h8000, 4'd15, SRA, 1'b1, 16'hFFFF, 1'b0};
        vt[10] = '{16'h0001, 4'd15, SLL, 1'b1, 16'h8000, 1'b0};
        vt[11] = '{16'h7FFF, 4'd15, SRA, 1'b1, 16'h0000, 1'b1};

        // Reset state.
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_q", q, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid_after", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // Directed vectors with exact latency.
        for (int i = 0; i < 12; i++) begin
            send(vt[i].d, vt[i].sh, vt[i].m, vt[i].e);
            expect_out($sformatf("vec%0d", i), vt[i].eq, vt[i].ec);
        end
        drain();

        // Back-pressure: six words back-to-back, consumer stalls 3 cycles.
        out_log.delete();
        fork
            begin
                for (int w = 1; w <= 6; w++) send(W'(w), 4'd1, SLL, 1'b1);
            end
            begin
                bit           seen;
                logic [W-1:0] hq;
                seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(posedge clk);
                    #2;
                    seen = out_valid;
                end
                chk("bp_first_valid", 32'(out_valid), 1);
                chk("bp_first_q", q, 16'd2);
                out_ready = 1'b0;
                hq = q;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 0);
                    chk("bp_q_held", q, hq);
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", out_log.size(), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++)
            chk($sformatf("bp_order%0d", i), out_log[i], 2 * (i + 1));

        // Reset with words in flight.
        @(posedge clk);
        #1;
        send(16'h0101, 4'd1, SLL, 1'b1);
        send(16'h0202, 4'd2, SRL, 1'b1);
        send(16'h0303, 4'd3, ROL, 1'b1);
        @(posedge clk);
        #1;
        chk("rs_pre_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("rs_out_valid", 32'(out_valid), 0);
        chk("rs_q", q, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            chk("rs_no_stale", 32'(out_valid), 0);
        end
        send(16'h00F0, 4'd4, SLL, 1'b1);
        expect_out("rs_next", 16'h0F00, 1'b0);
        drain();

        // Randomized traffic with random consumer stalls.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(W'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                         $urandom_range(0, 5) != 0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
